// File: rtl/level_tile_arbiter.sv
// Shares the single-port level-map ROM between the display tile lookahead and
// the collision query port. Display fetches are deadline-scheduled and always win.
module level_tile_arbiter #(
   parameter int H_START = 144,
   parameter int V_START = 35,
   parameter int LEAD    = 4,
   parameter int TILES_X = 20,
   parameter int TILES_Y = 15,
   parameter int LVL_W   = 2,
   parameter int ADDR_W  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frameStart,
   input  logic [9:0]        hCount,
   input  logic [9:0]        vCount,
   input  logic [LVL_W-1:0]  level_sel,
   input  logic              q_valid,
   input  logic [8:0]        q_addr,
   output logic              q_ready,
   output logic              r_valid,
   output logic [2:0]        r_data,
   output logic              r_err,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [2:0]        mem_rdata,
   output logic [2:0]        blockType
);

   localparam logic [9:0]  H_START_W  = 10'(H_START);
   localparam logic [9:0]  V_START_W  = 10'(V_START);
   localparam logic [9:0]  LEAD_W     = 10'(LEAD);
   localparam logic [9:0]  V_VISIBLE  = 10'(32 * TILES_Y);
   localparam logic [5:0]  COLS_W     = 6'(TILES_X);
   localparam logic [31:0] TILE_COUNT = 32'(TILES_X * TILES_Y);

   logic [9:0]        xPos;
   logic [9:0]        yPos;
   logic [9:0]        xLead;
   logic [9:0]        xNext;
   logic              yVisible;
   logic              dispFetch;
   logic              tileLoad;
   logic              qAccept;
   logic              qInRange;
   logic [LVL_W-1:0]  levelReg;
   logic [ADDR_W-1:0] levelBase;
   logic [ADDR_W-1:0] dispOffset;
   logic [2:0]        nextTile;
   logic              fetchPending;
   logic              qStage1;
   logic              qStage1Err;
   logic              respValid;

   // Raster position relative to the first visible pixel; all arithmetic wraps at 10 bits
   assign xPos     = hCount - H_START_W;
   assign yPos     = vCount - V_START_W;
   assign xLead    = xPos + LEAD_W;
   assign xNext    = xPos + 10'd1;
   assign yVisible = yPos < V_VISIBLE;

   assign dispFetch = rst_n && yVisible && (xLead[4:0] == 5'd0) && ({1'b0, xLead[9:5]} < COLS_W);
   assign tileLoad  = yVisible && (xNext[4:0] == 5'd0) && ({1'b0, xNext[9:5]} < COLS_W);

   assign levelBase  = ADDR_W'(32'(levelReg) * TILE_COUNT);
   assign dispOffset = ADDR_W'(32'(yPos[9:5]) * 32'(TILES_X) + 32'(xLead[9:5]));

   assign qInRange = 32'(q_addr) < TILE_COUNT;
   assign q_ready  = rst_n && !dispFetch;
   assign qAccept  = q_valid && q_ready;

   // Out-of-range queries still occupy a pipeline slot but never touch the ROM
   assign mem_en   = dispFetch || (qAccept && qInRange);
   assign mem_addr = levelBase + (dispFetch ? dispOffset : ADDR_W'(q_addr));

   // A response strobe that would land in a reset cycle is dropped, not delayed
   assign r_valid = respValid && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         levelReg     <= '0;
         nextTile     <= '0;
         blockType    <= '0;
         fetchPending <= 1'b0;
         qStage1      <= 1'b0;
         qStage1Err   <= 1'b0;
         respValid    <= 1'b0;
         r_data       <= '0;
         r_err        <= 1'b0;
      end else begin
         if (frameStart) begin
            levelReg <= level_sel;
         end
         fetchPending <= dispFetch;
         if (fetchPending) begin
            nextTile <= mem_rdata;
         end
         if (tileLoad) begin
            blockType <= nextTile;
         end
         qStage1    <= qAccept;
         qStage1Err <= qAccept && !qInRange;
         respValid  <= qStage1;
         if (qStage1) begin
            r_data <= qStage1Err ? 3'd0 : mem_rdata;
            r_err  <= qStage1Err;
         end
      end
   end

endmodule

// File: tb/tb_level_tile_arbiter.sv
// Randomised raster-line stimulus for level_tile_arbiter; a monitor compares every
// cycle against a tile-map reference model and a response scoreboard.
module tb_level_tile_arbiter;

   localparam int H_START    = 144;
   localparam int V_START    = 35;
   localparam int LEAD       = 4;
   localparam int TILES_X    = 20;
   localparam int TILES_Y    = 15;
   localparam int LVL_W      = 2;
   localparam int ADDR_W     = 11;
   localparam int TILE_COUNT = TILES_X * TILES_Y;

   typedef struct {
      int       due;
      logic [2:0] data;
      logic     err;
   } resp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              frameStart = 1'b0;
   logic [9:0]        hCount = '0;
   logic [9:0]        vCount = '0;
   logic [LVL_W-1:0]  level_sel = '0;
   logic              q_valid = 1'b0;
   logic [8:0]        q_addr = '0;
   logic              q_ready;
   logic              r_valid;
   logic [2:0]        r_data;
   logic              r_err;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_rdata = '0;
   logic [2:0]        blockType;

   logic [2:0] romMem [0:2047];
   resp_t      respQ[$];

   int   cycle = 0;
   int   checks = 0;
   int   errors = 0;
   bit   running = 1'b0;
   bit   accNow = 1'b0;
   int   modelLevel = 0;
   logic [2:0] expBT = '0;
   bit   btKnown = 1'b0;
   int   lastReset = -100;
   int   fetchCycle = -1000;
   logic [2:0] fetchVal = '0;
   logic [2:0] lastData = '0;
   logic lastErr = 1'b0;

   level_tile_arbiter #(
      .H_START(H_START), .V_START(V_START), .LEAD(LEAD), .TILES_X(TILES_X),
      .TILES_Y(TILES_Y), .LVL_W(LVL_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frameStart(frameStart), .hCount(hCount), .vCount(vCount),
      .level_sel(level_sel), .q_valid(q_valid), .q_addr(q_addr), .q_ready(q_ready),
      .r_valid(r_valid), .r_data(r_data), .r_err(r_err), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .blockType(blockType)
   );

   always #5 clk = ~clk;

   // Synchronous level-map ROM: data appears the cycle after the read
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= romMem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, actual, expected);
      end
   endtask

   function automatic logic [8:0] pickAddr();
      int r;
      r = int'($urandom % 8);
      if (r == 0) return 9'd299;
      if (r == 1) return 9'd300;
      if (r == 2) return 9'($urandom % 512);
      return 9'($urandom % TILE_COUNT);
   endfunction

   // Monitor: checks the cycle, then advances the model across the coming edge
   always @(negedge clk) begin
      int h, v, row, fetchCol, loadCol, fetchAddr;
      bit vis, fetchNow, boundary, inRange;
      logic expQready, accepted, expMemEn;
      resp_t e;
      if (running) begin
         h = int'(hCount);
         v = int'(vCount);
         vis = (v >= V_START) && (v < V_START + 32 * TILES_Y);
         row = (v - V_START) / 32;
         fetchNow = 1'b0; boundary = 1'b0; fetchCol = 0; loadCol = 0;
         for (int t = 0; t < TILES_X; t++) begin
            if (h == H_START - LEAD + 32 * t) begin fetchNow = vis; fetchCol = t; end
            if (h == H_START - 1 + 32 * t) begin boundary = vis; loadCol = t; end
         end
         fetchNow  = fetchNow && rst_n;
         fetchAddr = modelLevel * TILE_COUNT + row * TILES_X + fetchCol;
         inRange   = int'(q_addr) < TILE_COUNT;
         expQready = rst_n && !fetchNow;
         accepted  = q_valid && expQready;
         expMemEn  = fetchNow || (accepted && inRange);

         checkOutput("q_ready", 32'(q_ready), 32'(expQready));
         checkOutput("mem_en", 32'(mem_en), 32'(expMemEn));
         if (fetchNow) begin
            checkOutput("fetch_addr", 32'(mem_addr), 32'(fetchAddr));
            fetchVal   = romMem[fetchAddr];
            fetchCycle = cycle;
         end else if (accepted && inRange) begin
            checkOutput("query_addr", 32'(mem_addr), 32'(modelLevel * TILE_COUNT + int'(q_addr)));
         end
         if (btKnown) checkOutput("blockType", 32'(blockType), 32'(expBT));

         if (!rst_n) begin
            respQ.delete();
            checkOutput("r_valid_in_reset", 32'(r_valid), 32'(0));
         end else if (respQ.size() > 0 && respQ[0].due == cycle) begin
            e = respQ.pop_front();
            checkOutput("r_valid", 32'(r_valid), 32'(1));
            checkOutput("r_data", 32'(r_data), 32'(e.data));
            checkOutput("r_err", 32'(r_err), 32'(e.err));
            lastData = e.data;
            lastErr  = e.err;
         end else begin
            checkOutput("r_valid_idle", 32'(r_valid), 32'(0));
            checkOutput("r_data_hold", 32'(r_data), 32'(lastData));
            checkOutput("r_err_hold", 32'(r_err), 32'(lastErr));
         end

         if (accepted) begin
            e.due  = cycle + 2;
            e.data = inRange ? romMem[modelLevel * TILE_COUNT + int'(q_addr)] : 3'd0;
            e.err  = !inRange;
            respQ.push_back(e);
         end
         accNow = accepted;

         if (!rst_n) begin
            modelLevel = 0; expBT = '0; btKnown = 1'b1; lastReset = cycle;
            lastData = '0; lastErr = 1'b0;
         end else begin
            if (boundary) begin
               btKnown = (fetchCycle == cycle - (LEAD - 1)) && (fetchCycle > lastReset);
               expBT   = fetchVal;
               if (loadCol < 0) btKnown = 1'b0;
            end
            if (frameStart) modelLevel = int'(level_sel);
         end
         cycle++;
      end
   end

   // One raster line of 800 clocks; optional frame start and a one-cycle reset pulse
   task automatic applyStimulus(input int vLine, input bit doFrame, input int newLevel, input int resetAt);
      for (int h = 0; h < 800; h++) begin
         @(posedge clk);
         #1;
         hCount     = 10'(h);
         vCount     = 10'(vLine);
         frameStart = doFrame && (h == 0);
         if (doFrame && h == 0) level_sel = LVL_W'(newLevel);
         else if ($urandom % 64 == 0) level_sel = LVL_W'($urandom % 4);
         rst_n = !(h == resetAt);
         if (!q_valid || accNow) begin
            if (resetAt >= 0 && h >= resetAt - 3 && h < resetAt) begin
               q_valid = 1'b1;
               q_addr  = 9'($urandom % TILE_COUNT);
            end else begin
               q_valid = ($urandom % 2) == 1;
               q_addr  = pickAddr();
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) romMem[i] = 3'($urandom % 8);
      running = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(99, 1'b1, 1, -1);
      applyStimulus(35, 1'b1, 0, -1);
      applyStimulus(60, 1'b0, 0, -1);
      applyStimulus(300, 1'b1, 2, -1);
      applyStimulus(120, 1'b0, 0, 310);
      applyStimulus(150, 1'b0, 0, -1);
      applyStimulus(514, 1'b1, 3, -1);
      applyStimulus(515, 1'b0, 0, -1);
      applyStimulus(34, 1'b0, 0, -1);
      for (int n = 0; n < 16; n++) begin
         applyStimulus(int'($urandom % 525), ($urandom % 4) == 0, int'($urandom % 4), -1);
      end

      @(posedge clk);
      #1;
      hCount  = 10'd800;
      q_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      running = 1'b0;
      checkOutput("drain", 32'(respQ.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
